// File: rtl/alu_response_checker_if.sv
// Bus bundle between the vector sequencer / ALU side and alu_response_checker.
// The master drives the vectors and ALU results; the slave returns status and statistics.
interface alu_response_checker_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             vec_valid;
  logic             vec_last;
  logic [3:0]       vec_sel;
  logic [7:0]       vec_exp_out;
  logic             vec_exp_carry;
  logic [7:0]       alu_out;
  logic             alu_carry;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] checked_cnt;
  logic [CNT_W-1:0] error_cnt;
  logic             first_err_vld;
  logic [CNT_W-1:0] first_err_idx;
  logic [8:0]       first_err_got;
  logic [8:0]       first_err_exp;
  logic [15:0]      signature;

  modport master (
    output start, vec_valid, vec_last, vec_sel, vec_exp_out, vec_exp_carry,
           alu_out, alu_carry,
    input  busy, done, checked_cnt, error_cnt, first_err_vld, first_err_idx,
           first_err_got, first_err_exp, signature
  );

  modport slave (
    input  start, vec_valid, vec_last, vec_sel, vec_exp_out, vec_exp_carry,
           alu_out, alu_carry,
    output busy, done, checked_cnt, error_cnt, first_err_vld, first_err_idx,
           first_err_got, first_err_exp, signature
  );
endinterface

// File: rtl/alu_response_checker.sv
// Response checker for the registered ALU: re-times expected results by ALU_LATENCY and compares.
// Optional MISR signature over compared ALU results is enabled by defining MISR_SIGNATURE_EN.
module alu_response_checker #(
  parameter int         ALU_LATENCY = 1,
  parameter int         CNT_W       = 32,
  parameter logic [3:0] SKIP_SEL    = 4'b0011
) (
  input logic                   clock,
  input logic                   reset,
  alu_response_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic   clr;
  logic   accept;
  logic   line_busy;
  logic   cmp;
  logic   mism;
  logic [8:0] got;

  logic [ALU_LATENCY-1:0] vld_p;
  logic [CNT_W-1:0]       idx_p [ALU_LATENCY];
  logic [3:0]             sel_p [ALU_LATENCY];
  logic [8:0]             exp_p [ALU_LATENCY];

  logic [CNT_W-1:0] vec_idx;
  logic [CNT_W-1:0] checked_q;
  logic [CNT_W-1:0] error_q;
  logic             ferr_vld_q;
  logic [CNT_W-1:0] ferr_idx_q;
  logic [8:0]       ferr_got_q;
  logic [8:0]       ferr_exp_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign accept    = (state_q == RUN) && bus.vec_valid;
  assign line_busy = |vld_p;
  assign got       = {bus.alu_carry, bus.alu_out};
  assign cmp       = vld_p[ALU_LATENCY-1] && (sel_p[ALU_LATENCY-1] != SKIP_SEL);
  assign mism      = cmp && (got != exp_p[ALU_LATENCY-1]);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) begin state_d = RUN; clr = 1'b1; end
      RUN:   if (accept && bus.vec_last) state_d = DRAIN;
      DRAIN: if (!line_busy) state_d = DONE;
      DONE:  if (bus.start) begin state_d = RUN; clr = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: delay line, valid bits flushed by reset, payload free-running
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < ALU_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    idx_p[0] <= vec_idx;
    sel_p[0] <= bus.vec_sel;
    exp_p[0] <= {bus.vec_exp_carry, bus.vec_exp_out};
    for (int i = 1; i < ALU_LATENCY; i++) begin
      idx_p[i] <= idx_p[i-1];
      sel_p[i] <= sel_p[i-1];
      exp_p[i] <= exp_p[i-1];
    end
  end

  // Stage boundary: compare at the tail of the delay line, update statistics
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      vec_idx    <= '0;
      checked_q  <= '0;
      error_q    <= '0;
      ferr_vld_q <= 1'b0;
      ferr_idx_q <= '0;
      ferr_got_q <= '0;
      ferr_exp_q <= '0;
    end else begin
      if (accept) vec_idx <= vec_idx + {{(CNT_W-1){1'b0}}, 1'b1};
      if (cmp) checked_q <= sat_inc(checked_q);
      if (mism) begin
        error_q <= sat_inc(error_q);
        if (!ferr_vld_q) begin
          ferr_vld_q <= 1'b1;
          ferr_idx_q <= idx_p[ALU_LATENCY-1];
          ferr_got_q <= got;
          ferr_exp_q <= exp_p[ALU_LATENCY-1];
        end
      end
    end
  end

`ifdef MISR_SIGNATURE_EN
  logic [15:0] misr_q;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [8:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {7'b0, d};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset || clr) misr_q <= 16'hFFFF;
    else if (cmp)      misr_q <= misr_step(misr_q, got);
  end

  assign bus.signature = misr_q;
`else
  assign bus.signature = 16'h0000;
`endif

  assign bus.busy          = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done          = (state_q == DONE);
  assign bus.checked_cnt   = checked_q;
  assign bus.error_cnt     = error_q;
  assign bus.first_err_vld = ferr_vld_q;
  assign bus.first_err_idx = ferr_idx_q;
  assign bus.first_err_got = ferr_got_q;
  assign bus.first_err_exp = ferr_exp_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed bench: two checkers (ALU_LATENCY 1 and 3) see the same vectors, each fed by its own
// emulated ALU delay. Signature checks follow MISR_SIGNATURE_EN.
module tb_alu_response_checker;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alu_response_checker_if #(.CNT_W(32)) bus1 ();
  alu_response_checker_if #(.CNT_W(32)) bus3 ();

  alu_response_checker #(.ALU_LATENCY(1), .CNT_W(32)) u1 (.clock(clock), .reset(reset), .bus(bus1.slave));
  alu_response_checker #(.ALU_LATENCY(3), .CNT_W(32)) u3 (.clock(clock), .reset(reset), .bus(bus3.slave));

  logic [8:0] got_b = 9'h000;
  logic [8:0] gp [3];

  always @(posedge clock) begin
    gp[0] <= got_b;
    gp[1] <= gp[0];
    gp[2] <= gp[1];
  end

  assign bus1.alu_out   = gp[0][7:0];
  assign bus1.alu_carry = gp[0][8];
  assign bus3.alu_out   = gp[2][7:0];
  assign bus3.alu_carry = gp[2][8];
  assign bus3.start         = bus1.start;
  assign bus3.vec_valid     = bus1.vec_valid;
  assign bus3.vec_last      = bus1.vec_last;
  assign bus3.vec_sel       = bus1.vec_sel;
  assign bus3.vec_exp_out   = bus1.vec_exp_out;
  assign bus3.vec_exp_carry = bus1.vec_exp_carry;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] sig_a, sig_b, sig_c;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] sel, input logic [8:0] exp, input logic [8:0] got, input bit last);
    bus1.vec_valid     = 1'b1;
    bus1.vec_last      = last;
    bus1.vec_sel       = sel;
    bus1.vec_exp_out   = exp[7:0];
    bus1.vec_exp_carry = exp[8];
    got_b              = got;
    step();
    bus1.vec_valid = 1'b0;
    bus1.vec_last  = 1'b0;
    got_b          = 9'h000;
  endtask

  task automatic pulse_start();
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("busy_after_start_l1", 32'(bus1.busy), 32'd1);
    chk("busy_after_start_l3", 32'(bus3.busy), 32'd1);
  endtask

  task automatic drain_check(input string tag);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk({tag, "_done_l1"}, 32'(bus1.done), 32'(k >= 2));
      chk({tag, "_done_l3"}, 32'(bus3.done), 32'(k >= 4));
    end
  endtask

  task automatic stats(input string tag, input logic [31:0] c, input logic [31:0] e,
                       input logic v, input logic [31:0] idx, input logic [8:0] g, input logic [8:0] x);
    chk({tag, "_checked_l1"}, bus1.checked_cnt, c);
    chk({tag, "_checked_l3"}, bus3.checked_cnt, c);
    chk({tag, "_errors_l1"}, bus1.error_cnt, e);
    chk({tag, "_errors_l3"}, bus3.error_cnt, e);
    chk({tag, "_fvld_l1"}, 32'(bus1.first_err_vld), 32'(v));
    chk({tag, "_fvld_l3"}, 32'(bus3.first_err_vld), 32'(v));
    chk({tag, "_fidx_l1"}, bus1.first_err_idx, idx);
    chk({tag, "_fidx_l3"}, bus3.first_err_idx, idx);
    chk({tag, "_fgot_l1"}, 32'(bus1.first_err_got), 32'(g));
    chk({tag, "_fgot_l3"}, 32'(bus3.first_err_got), 32'(g));
    chk({tag, "_fexp_l1"}, 32'(bus1.first_err_exp), 32'(x));
    chk({tag, "_fexp_l3"}, 32'(bus3.first_err_exp), 32'(x));
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_busy_l1"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_busy_l3"}, 32'(bus3.busy), 32'd0);
    chk({tag, "_done_l1"}, 32'(bus1.done), 32'd0);
    chk({tag, "_done_l3"}, 32'(bus3.done), 32'd0);
    stats(tag, 32'd0, 32'd0, 1'b0, 32'd0, 9'h000, 9'h000);
`ifndef MISR_SIGNATURE_EN
    chk({tag, "_sig_l1"}, 32'(bus1.signature), 32'd0);
    chk({tag, "_sig_l3"}, 32'(bus3.signature), 32'd0);
`endif
  endtask

  task automatic run_seq(input bit flip);
    pulse_start();
    send(4'h0, 9'h008, 9'h008, 1'b0);
    send(4'h0, 9'h008, flip ? 9'h009 : 9'h008, 1'b0);
    send(4'h0, 9'h008, 9'h008, 1'b1);
    drain_check(flip ? "seq_flip" : "seq");
  endtask

  initial begin
    bus1.start = 1'b0; bus1.vec_valid = 1'b0; bus1.vec_last = 1'b0;
    bus1.vec_sel = 4'h0; bus1.vec_exp_out = 8'h00; bus1.vec_exp_carry = 1'b0;

    step(); step();
    zero_outputs("reset");
    reset = 1'b1;
    step();

    // Three matching vectors, last on the third
    run_seq(1'b0);
    stats("t1", 32'd3, 32'd0, 1'b0, 32'd0, 9'h000, 9'h000);
    sig_a = bus1.signature;

    // First-failure capture, later mismatch ignored, skipped sel still indexed
    pulse_start();
    send(4'h1, 9'h010, 9'h010, 1'b0);
    send(4'h3, 9'h155, 9'h000, 1'b0);
    send(4'h2, 9'h010, 9'h011, 1'b0);
    send(4'h4, 9'h120, 9'h021, 1'b0);
    send(4'h5, 9'h07F, 9'h07F, 1'b1);
    drain_check("t2");
    stats("t2", 32'd4, 32'd2, 1'b1, 32'd2, 9'h011, 9'h010);

    // Reset mid-run discards everything; vectors ignored until start
    pulse_start();
    for (int i = 0; i < 5; i++) send(4'h0, 9'h020, (i == 1) ? 9'h021 : 9'h020, 1'b0);
    reset = 1'b0;
    step();
    zero_outputs("t4_rst");
    reset = 1'b1;
    bus1.vec_valid = 1'b1; bus1.vec_last = 1'b1;
    step(); step(); step();
    bus1.vec_valid = 1'b0; bus1.vec_last = 1'b0;
    zero_outputs("t4_idle");

    // Ten back-to-back vectors, carry-only error on idx 7
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      logic [8:0] e;
      e = {1'b0, 8'(i * 17)};
      send(4'h7, e, (i == 7) ? {1'b1, e[7:0]} : e, i == 9);
    end
    drain_check("t5");
    stats("t5", 32'd10, 32'd1, 1'b1, 32'd7, 9'h177, 9'h077);
    chk("t5_carry_differs_l3", 32'(bus3.first_err_got[8] !== bus3.first_err_exp[8]), 32'd1);

    // Signature: identical rerun, then one flipped alu_out bit
    run_seq(1'b0);
    sig_b = bus1.signature;
    chk("sig_rerun_l3", 32'(bus3.signature), 32'(sig_b));
    run_seq(1'b1);
    sig_c = bus1.signature;
    chk("seq_flip_errors_l1", bus1.error_cnt, 32'd1);
`ifdef MISR_SIGNATURE_EN
    chk("sig_repeat", 32'(sig_b), 32'(sig_a));
    chk("sig_nonzero", 32'(sig_a != 16'h0000), 32'd1);
    chk("sig_flip_differs", 32'(sig_c != sig_a), 32'd1);
`else
    chk("sig_a_zero", 32'(sig_a), 32'd0);
    chk("sig_b_zero", 32'(sig_b), 32'd0);
    chk("sig_c_zero", 32'(sig_c), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
